lsu_mem_stage: RTL and testbench

- Memory-access stage between the combined decode/execute logic and register writeback in the single-issue RV32 core.
- Accepts one executed instruction per handshake and issues at most one word-aligned request to the data-memory port (SRAM model).
- Aligns, masks and sign-extends load data, then hands a writeback record downstream.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_mem_stage_pkg.sv | 17 +
 rtl/lsu_mem_stage_if.sv | 43 ++++
 rtl/lsu_mem_stage_align.sv | 45 ++++
 rtl/lsu_mem_stage.sv | 135 +++++++++++++
 tb/tb_lsu_mem_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory stage: funct3 size codes and FSM states.
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Bundle of the upstream, writeback and data-memory handshakes of the LSU stage.
// master = surrounding pipeline/memory, slave = the stage itself.
interface lsu_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_wdata;
  logic        out_wen;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  modport master (
    output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
           in_alu_result, in_rd, out_ready, mem_req_ready, mem_resp_valid,
           mem_resp_rdata,
    input  in_ready, out_valid, out_rd, out_wdata, out_wen, out_err,
           mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
           in_alu_result, in_rd, out_ready, mem_req_ready, mem_resp_valid,
           mem_resp_rdata,
    output in_ready, out_valid, out_rd, out_wdata, out_wen, out_err,
           mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/lsu_mem_stage_align.sv
// Combinational byte-lane logic: store replication/mask, load extract/extend,
// misalignment detection. Unused funct3 codes fall through to word access.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] store_lanes,
  output logic [3:0]  store_mask,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic        is_byte;
  logic        is_half;
  logic        is_unsigned;
  logic [31:0] shifted;

  // Decode access size and build lanes for both directions.
  always_comb begin
    is_byte     = (funct3 == F3_B) || (is_load && funct3 == F3_BU);
    is_half     = (funct3 == F3_H) || (is_load && funct3 == F3_HU);
    is_unsigned = is_load && (funct3 == F3_BU || funct3 == F3_HU);
    shifted     = load_word >> {addr_lo, 3'b000};
    store_lanes = store_data;
    store_mask  = '1;
    load_data   = shifted;
    misaligned  = (addr_lo != 2'b00);
    if (is_byte) begin
      store_lanes = {4{store_data[7:0]}};
      store_mask  = 4'b0001 << addr_lo;
      load_data   = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
      misaligned  = 1'b0;
    end else if (is_half) begin
      store_lanes = {2{store_data[15:0]}};
      store_mask  = 4'b0011 << addr_lo;
      load_data   = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
      misaligned  = addr_lo[0];
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32 memory-access stage: one instruction in flight, at most one word-aligned
// memory request, aligned/extended writeback record out.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  lsu_mem_stage_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     funct3_q;
  logic [1:0]     addr_lo_q;
  logic [4:0]     rd_q;
  logic           is_load_q;

  logic [2:0]     sel_funct3;
  logic [1:0]     sel_addr_lo;
  logic           sel_is_load;
  logic [31:0]    store_lanes;
  logic [3:0]     store_mask;
  logic [31:0]    load_data;
  logic           misaligned;

  // One lane unit serves both accept (live inputs) and response (captured fields).
  always_comb begin
    sel_funct3  = (state == ST_IDLE) ? bus.in_funct3   : funct3_q;
    sel_addr_lo = (state == ST_IDLE) ? bus.in_addr[1:0] : addr_lo_q;
    sel_is_load = (state == ST_IDLE) ? bus.in_is_load  : is_load_q;
  end

  lsu_align u_align (
    .funct3      (sel_funct3),
    .is_load     (sel_is_load),
    .addr_lo     (sel_addr_lo),
    .store_data  (bus.in_wdata),
    .load_word   (bus.mem_resp_rdata),
    .store_lanes (store_lanes),
    .store_mask  (store_mask),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  // Stage FSM with all handshake and record outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      funct3_q          <= '0;
      addr_lo_q         <= '0;
      rd_q              <= '0;
      is_load_q         <= 1'b0;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.out_rd        <= '0;
      bus.out_wdata     <= '0;
      bus.out_wen       <= 1'b0;
      bus.out_err       <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_req_wen   <= 1'b0;
      bus.mem_req_wdata <= '0;
      bus.mem_req_wmask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            funct3_q     <= bus.in_funct3;
            addr_lo_q    <= bus.in_addr[1:0];
            rd_q         <= bus.in_rd;
            is_load_q    <= bus.in_is_load;
            bus.in_ready <= 1'b0;
            bus.out_rd   <= bus.in_rd;
            bus.out_err  <= 1'b0;
            if (!bus.in_is_load && !bus.in_is_store) begin
              state         <= ST_OUT;
              bus.out_valid <= 1'b1;
              bus.out_wdata <= bus.in_alu_result;
              bus.out_wen   <= (bus.in_rd != 5'd0);
            end else if (misaligned) begin
              state         <= ST_OUT;
              bus.out_valid <= 1'b1;
              bus.out_wdata <= '0;
              bus.out_wen   <= 1'b0;
              bus.out_err   <= 1'b1;
            end else begin
              state             <= ST_REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= {bus.in_addr[31:2], 2'b00};
              bus.mem_req_wen   <= bus.in_is_store;
              bus.mem_req_wdata <= bus.in_is_store ? store_lanes : '0;
              bus.mem_req_wmask <= bus.in_is_store ? store_mask : '0;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            state             <= ST_WAIT;
            bus.mem_req_valid <= 1'b0;
            cnt               <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_resp_valid) begin
            state         <= ST_OUT;
            bus.out_valid <= 1'b1;
            bus.out_wdata <= is_load_q ? load_data : '0;
            bus.out_wen   <= is_load_q && (rd_q != 5'd0);
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state         <= ST_OUT;
            bus.out_valid <= 1'b1;
            bus.out_wdata <= '0;
            bus.out_wen   <= 1'b0;
            bus.out_err   <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with hand-computed expectations.
module tb_lsu_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count completed writeback handshakes.
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] alu, input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.in_is_load    = ld;
    bus.in_is_store   = st;
    bus.in_funct3     = f3;
    bus.in_addr       = addr;
    bus.in_wdata      = wd;
    bus.in_alu_result = alu;
    bus.in_rd         = rd;
  endtask

  // Accept edge, then drop in_valid.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] alu, input logic [4:0] rd);
    drive(ld, st, f3, addr, wd, alu, rd);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("release_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_is_load     = 1'b0;
    bus.in_is_store    = 1'b0;
    bus.in_funct3      = 3'd0;
    bus.in_addr        = '0;
    bus.in_wdata       = '0;
    bus.in_alu_result  = '0;
    bus.in_rd          = '0;
    bus.out_ready      = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_out_wdata", bus.out_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // ALU pass-through, rd = 5
    issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd5);
    check("alu_valid", {31'd0, bus.out_valid}, 32'd1);
    check("alu_wdata", bus.out_wdata, 32'h1234);
    check("alu_wen", {31'd0, bus.out_wen}, 32'd1);
    check("alu_rd", {27'd0, bus.out_rd}, 32'd5);
    check("alu_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("alu_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    release_out();

    // ALU pass-through, rd = 0
    issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd0);
    check("alu0_valid", {31'd0, bus.out_valid}, 32'd1);
    check("alu0_wen", {31'd0, bus.out_wen}, 32'd0);
    release_out();

    // LB at 0x80000003
    issue(1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h0, 5'd7);
    check("lb_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    check("lb_req_addr", bus.mem_req_addr, 32'h8000_0000);
    check("lb_req_wen", {31'd0, bus.mem_req_wen}, 32'd0);
    tick();
    check("lb_req_done", {31'd0, bus.mem_req_valid}, 32'd0);
    check("lb_not_yet", {31'd0, bus.out_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h80FF_7F01;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("lb_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lb_wdata", bus.out_wdata, 32'hFFFF_FF80);
    check("lb_wen", {31'd0, bus.out_wen}, 32'd1);
    check("lb_err", {31'd0, bus.out_err}, 32'd0);
    release_out();

    // LBU, with a response in the handshake cycle that must be ignored
    issue(1'b1, 1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h0, 5'd7);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0000_0000;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("lbu_early_resp", {31'd0, bus.out_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h80FF_7F01;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("lbu_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lbu_wdata", bus.out_wdata, 32'h0000_0080);
    release_out();

    // SH at 0x80000002
    issue(1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 5'd3);
    check("sh_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    check("sh_req_wen", {31'd0, bus.mem_req_wen}, 32'd1);
    check("sh_req_wdata", bus.mem_req_wdata, 32'hABCD_ABCD);
    check("sh_req_wmask", {28'd0, bus.mem_req_wmask}, 32'hC);
    check("sh_req_addr", bus.mem_req_addr, 32'h8000_0000);
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("sh_valid", {31'd0, bus.out_valid}, 32'd1);
    check("sh_wen", {31'd0, bus.out_wen}, 32'd0);
    check("sh_wdata", bus.out_wdata, 32'd0);
    release_out();

    // Misaligned LW
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 5'd4);
    check("mis_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    check("mis_valid", {31'd0, bus.out_valid}, 32'd1);
    check("mis_err", {31'd0, bus.out_err}, 32'd1);
    check("mis_wen", {31'd0, bus.out_wen}, 32'd0);
    release_out();

    // LW timeout: four WAIT cycles without a response
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'h0, 5'd6);
    tick();
    tick();
    tick();
    tick();
    check("to_not_yet", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("to_valid", {31'd0, bus.out_valid}, 32'd1);
    check("to_err", {31'd0, bus.out_err}, 32'd1);
    check("to_wen", {31'd0, bus.out_wen}, 32'd0);
    release_out();

    // Backpressure on both sides
    bus.mem_req_ready = 1'b0;
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0020, 32'h0, 32'h0, 5'd9);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h5555, 5'd2);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      check("bp_req_addr", bus.mem_req_addr, 32'h8000_0020);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    check("bp_req_still", {31'd0, bus.mem_req_valid}, 32'd1);
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1122_3344;
    tick();
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_out_wdata", bus.out_wdata, 32'h1122_3344);
      check("bp_out_rd", {27'd0, bus.out_rd}, 32'd9);
      check("bp_in_ready2", {31'd0, bus.in_ready}, 32'd0);
      if (i < 2) tick();
    end
    bus.in_valid = 1'b0;
    release_out();
    tick();
    check("bp_single", {31'd0, bus.out_valid}, 32'd0);

    // Reset during WAIT, then a stale response
    issue(1'b1, 1'b0, 3'd2, 32'h8000_0040, 32'h0, 32'h0, 5'd8);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rw_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h7777_7777;
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    check("rw_stale", {31'd0, bus.out_valid}, 32'd0);
    check("rw_idle", {31'd0, bus.in_ready}, 32'd1);

    // Normal operation after reset
    issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_CAFE, 5'd1);
    check("post_wdata", bus.out_wdata, 32'h0000_CAFE);
    check("post_wen", {31'd0, bus.out_wen}, 32'd1);
    release_out();

    check("completions", n_done, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
